// File: rtl/axis_alu.sv
// Byte-stream ALU: receives opcode + two little-endian operands over AXI-Stream,
// returns the result LSB first with flags on tuser, or a single 0xFF error byte.
module axis_alu #(
  parameter int unsigned OPERAND_BYTES = 2,
  parameter int unsigned LED_WIDTH     = 16
) (
  input  logic                 aclk_i,
  input  logic                 arst_i,
  input  logic [7:0]           s_axis_tdata_i,
  input  logic                 s_axis_tvalid_i,
  input  logic                 s_axis_tlast_i,
  output logic                 s_axis_tready_o,
  output logic [7:0]           m_axis_tdata_o,
  output logic                 m_axis_tvalid_o,
  output logic                 m_axis_tlast_o,
  output logic [3:0]           m_axis_tuser_o,
  input  logic                 m_axis_tready_i,
  output logic [LED_WIDTH-1:0] led_o
);

  localparam int unsigned W     = 8 * OPERAND_BYTES;
  localparam int unsigned IDX_W = (OPERAND_BYTES > 1) ? $clog2(OPERAND_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OPERAND_BYTES - 1);
  localparam logic [W-1:0]     W_MOD    = W'(W);

  localparam logic [7:0] OP_ADD = 8'd0;
  localparam logic [7:0] OP_SUB = 8'd1;
  localparam logic [7:0] OP_AND = 8'd2;
  localparam logic [7:0] OP_OR  = 8'd3;
  localparam logic [7:0] OP_XOR = 8'd4;
  localparam logic [7:0] OP_SHL = 8'd5;
  localparam logic [7:0] OP_SHR = 8'd6;

  localparam logic [7:0] ERR_BYTE = 8'hFF;
  localparam logic [3:0] ERR_USER = 4'b1000;

  typedef enum logic [2:0] {
    ST_OPC,
    ST_RX_A,
    ST_RX_B,
    ST_EXEC,
    ST_TX,
    ST_DRAIN,
    ST_ERR_TX
  } state_e;

  typedef logic [OPERAND_BYTES-1:0][7:0] operand_t;

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       cnt_q, cnt_d;
  logic [7:0]             opc_q, opc_d;
  operand_t               a_q, a_d;
  operand_t               b_q, b_d;
  operand_t               res_q, res_d;
  logic                   s_tready_q, s_tready_d;
  logic                   m_tvalid_q, m_tvalid_d;
  logic [7:0]             m_tdata_q, m_tdata_d;
  logic                   m_tlast_q, m_tlast_d;
  logic [3:0]             m_tuser_q, m_tuser_d;
  logic [LED_WIDTH-1:0]   led_q, led_d;

  logic                   s_hs_c;
  logic                   m_hs_c;
  logic [IDX_W-1:0]       cnt_inc_c;
  logic [W-1:0]           a_w_c;
  logic [W-1:0]           b_w_c;
  logic [W-1:0]           sh_c;
  logic [W:0]             wide_c;
  logic [W-1:0]           alu_res_c;
  logic                   alu_carry_c;
  logic                   op_ok_c;
  logic [3:0]             flags_c;

  assign s_hs_c    = s_tready_q & s_axis_tvalid_i;
  assign m_hs_c    = m_tvalid_q & m_axis_tready_i;
  assign cnt_inc_c = cnt_q + 1'b1;
  assign a_w_c     = a_q;
  assign b_w_c     = b_q;
  assign sh_c      = b_w_c % W_MOD;

  // Combinational ALU on the captured operands; only consumed in EXEC.
  always_comb begin
    wide_c      = '0;
    alu_res_c   = '0;
    alu_carry_c = 1'b0;
    op_ok_c     = 1'b1;
    case (opc_q)
      OP_ADD: begin
        wide_c      = {1'b0, a_w_c} + {1'b0, b_w_c};
        alu_res_c   = wide_c[W-1:0];
        alu_carry_c = wide_c[W];
      end
      OP_SUB: begin
        wide_c      = {1'b0, a_w_c} - {1'b0, b_w_c};
        alu_res_c   = wide_c[W-1:0];
        alu_carry_c = wide_c[W];
      end
      OP_AND:  alu_res_c = a_w_c & b_w_c;
      OP_OR:   alu_res_c = a_w_c | b_w_c;
      OP_XOR:  alu_res_c = a_w_c ^ b_w_c;
      OP_SHL:  alu_res_c = a_w_c << sh_c;
      OP_SHR:  alu_res_c = a_w_c >> sh_c;
      default: op_ok_c   = 1'b0;
    endcase
    flags_c = {1'b0, alu_res_c[W-1], (alu_res_c == '0), alu_carry_c};
  end

  // Next-state, datapath capture and registered-output staging.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    opc_d      = opc_q;
    a_d        = a_q;
    b_d        = b_q;
    res_d      = res_q;
    m_tdata_d  = m_tdata_q;
    m_tlast_d  = m_tlast_q;
    m_tuser_d  = m_tuser_q;
    led_d      = led_q;

    case (state_q)
      ST_OPC: begin
        if (s_hs_c) begin
          opc_d   = s_axis_tdata_i;
          cnt_d   = '0;
          state_d = s_axis_tlast_i ? ST_ERR_TX : ST_RX_A;
        end
      end
      ST_RX_A: begin
        if (s_hs_c) begin
          a_d[cnt_q] = s_axis_tdata_i;
          if (s_axis_tlast_i) begin
            state_d = ST_ERR_TX;
          end else if (cnt_q == LAST_IDX) begin
            cnt_d   = '0;
            state_d = ST_RX_B;
          end else begin
            cnt_d = cnt_inc_c;
          end
        end
      end
      ST_RX_B: begin
        if (s_hs_c) begin
          b_d[cnt_q] = s_axis_tdata_i;
          if (cnt_q == LAST_IDX) begin
            cnt_d   = '0;
            state_d = s_axis_tlast_i ? ST_EXEC : ST_DRAIN;
          end else if (s_axis_tlast_i) begin
            state_d = ST_ERR_TX;
          end else begin
            cnt_d = cnt_inc_c;
          end
        end
      end
      ST_DRAIN: begin
        if (s_hs_c && s_axis_tlast_i) begin
          state_d = ST_ERR_TX;
        end
      end
      ST_EXEC: begin
        if (op_ok_c) begin
          res_d     = alu_res_c;
          led_d     = LED_WIDTH'(alu_res_c);
          m_tdata_d = alu_res_c[7:0];
          m_tlast_d = (LAST_IDX == '0);
          m_tuser_d = flags_c;
          cnt_d     = '0;
          state_d   = ST_TX;
        end else begin
          state_d = ST_ERR_TX;
        end
      end
      ST_TX: begin
        if (m_hs_c) begin
          if (cnt_q == LAST_IDX) begin
            cnt_d   = '0;
            state_d = ST_OPC;
          end else begin
            cnt_d     = cnt_inc_c;
            m_tdata_d = res_q[cnt_inc_c];
            m_tlast_d = (cnt_inc_c == LAST_IDX);
          end
        end
      end
      ST_ERR_TX: begin
        if (m_hs_c) begin
          state_d = ST_OPC;
        end
      end
      default: state_d = ST_OPC;
    endcase

    // Any path into the error state presents the single error byte.
    if ((state_d == ST_ERR_TX) && (state_q != ST_ERR_TX)) begin
      cnt_d     = '0;
      m_tdata_d = ERR_BYTE;
      m_tlast_d = 1'b1;
      m_tuser_d = ERR_USER;
    end

    s_tready_d = (state_d == ST_OPC) || (state_d == ST_RX_A) ||
                 (state_d == ST_RX_B) || (state_d == ST_DRAIN);
    m_tvalid_d = (state_d == ST_TX) || (state_d == ST_ERR_TX);
  end

  always_ff @(posedge aclk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q    <= ST_OPC;
      cnt_q      <= '0;
      opc_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      res_q      <= '0;
      s_tready_q <= 1'b0;
      m_tvalid_q <= 1'b0;
      m_tdata_q  <= '0;
      m_tlast_q  <= 1'b0;
      m_tuser_q  <= '0;
      led_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      opc_q      <= opc_d;
      a_q        <= a_d;
      b_q        <= b_d;
      res_q      <= res_d;
      s_tready_q <= s_tready_d;
      m_tvalid_q <= m_tvalid_d;
      m_tdata_q  <= m_tdata_d;
      m_tlast_q  <= m_tlast_d;
      m_tuser_q  <= m_tuser_d;
      led_q      <= led_d;
    end
  end

  assign s_axis_tready_o = s_tready_q;
  assign m_axis_tvalid_o = m_tvalid_q;
  assign m_axis_tdata_o  = m_tdata_q;
  assign m_axis_tlast_o  = m_tlast_q;
  assign m_axis_tuser_o  = m_tuser_q;
  assign led_o           = led_q;

endmodule

// File: tb/tb_axis_alu.sv
// Bench for axis_alu: directed command scenarios plus randomized packets
// checked against a packet-level reference model.
module tb_axis_alu;

  localparam int unsigned OB   = 2;
  localparam int unsigned W    = 8 * OB;
  localparam int unsigned LEDW = 16;

  logic            clk = 1'b0;
  logic            arst = 1'b1;
  logic [7:0]      s_tdata = '0;
  logic            s_tvalid = 1'b0;
  logic            s_tlast = 1'b0;
  logic            s_tready;
  logic [7:0]      m_tdata;
  logic            m_tvalid;
  logic            m_tlast;
  logic [3:0]      m_tuser;
  logic            m_tready = 1'b0;
  logic [LEDW-1:0] led;

  int passed = 0;
  int total  = 0;

  logic [7:0]      pb[$];
  bit              pl[$];
  logic [7:0]      rx_d[$];
  logic [3:0]      rx_u[$];
  logic            rx_l[$];
  logic [7:0]      exp_d[$];
  logic [3:0]      exp_u;
  logic [LEDW-1:0] exp_led = '0;

  always #5 clk = ~clk;

  axis_alu #(.OPERAND_BYTES(OB), .LED_WIDTH(LEDW)) dut (
    .aclk_i          (clk),
    .arst_i          (arst),
    .s_axis_tdata_i  (s_tdata),
    .s_axis_tvalid_i (s_tvalid),
    .s_axis_tlast_i  (s_tlast),
    .s_axis_tready_o (s_tready),
    .m_axis_tdata_o  (m_tdata),
    .m_axis_tvalid_o (m_tvalid),
    .m_axis_tlast_o  (m_tlast),
    .m_axis_tuser_o  (m_tuser),
    .m_axis_tready_i (m_tready),
    .led_o           (led)
  );

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [7:0] b, input bit l);
    pb.push_back(b);
    pl.push_back(l);
  endtask

  task automatic send_pkt(input int gap_pct);
    for (int i = 0; i < pb.size(); i++) begin
      int guard = 0;
      while ($urandom_range(99) < gap_pct) begin
        s_tvalid = 1'b0;
        cycle();
      end
      s_tdata  = pb[i];
      s_tlast  = pl[i];
      s_tvalid = 1'b1;
      while (!s_tready && guard < 200) begin
        cycle();
        guard++;
      end
      if (guard >= 200) begin
        total++;
        $display("FAIL send_timeout byte %0d: s_tready=%b, required 1", i, s_tready);
        s_tvalid = 1'b0;
        return;
      end
      cycle();
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic recv_resp(input int stall_first, input int stall_pct);
    int guard = 0;
    int stall_left = stall_first;
    bit done = 1'b0;
    bit holding = 1'b0;
    logic [7:0] hd = '0;
    logic       hl = 1'b0;
    logic [3:0] hu = '0;
    rx_d.delete();
    rx_u.delete();
    rx_l.delete();
    while (!done) begin
      if (holding) begin
        total++;
        if (m_tvalid !== 1'b1 || m_tdata !== hd || m_tlast !== hl || m_tuser !== hu)
          $display("FAIL hold_stable: got v=%b d=%h l=%b u=%b, required v=1 d=%h l=%b u=%b",
                   m_tvalid, m_tdata, m_tlast, m_tuser, hd, hl, hu);
        else passed++;
      end
      if (m_tvalid) begin
        total++;
        if (s_tready !== 1'b0) $display("FAIL s_tready_during_tx: got %b, required 0", s_tready);
        else passed++;
      end
      if (m_tvalid && stall_left > 0) begin
        m_tready = 1'b0;
        stall_left--;
      end else begin
        m_tready = ($urandom_range(99) >= stall_pct);
      end
      if (m_tvalid && m_tready) begin
        rx_d.push_back(m_tdata);
        rx_u.push_back(m_tuser);
        rx_l.push_back(m_tlast);
        done    = (m_tlast === 1'b1);
        holding = 1'b0;
      end else if (m_tvalid) begin
        holding = 1'b1;
        hd = m_tdata;
        hl = m_tlast;
        hu = m_tuser;
      end
      cycle();
      guard++;
      if (!done && guard > 300) begin
        total++;
        $display("FAIL recv_timeout: got %0d bytes, required a tlast byte", rx_d.size());
        done = 1'b1;
      end
    end
    m_tready = 1'b0;
  endtask

  // Reference: whole-packet interpretation from the command format rules.
  task automatic model();
    int n = 1 + 2 * OB;
    int first_last = -1;
    bit bad;
    longint unsigned a = 0, b = 0, r = 0, mask;
    bit c = 1'b0;
    mask = (64'd1 << W) - 1;
    exp_d.delete();
    for (int i = 0; i < pl.size(); i++)
      if (pl[i] && first_last < 0) first_last = i;
    bad = (first_last != n - 1);
    if (!bad) begin
      for (int i = 0; i < OB; i++) begin
        a = a | (longint'(pb[1 + i]) << (8 * i));
        b = b | (longint'(pb[1 + OB + i]) << (8 * i));
      end
      case (pb[0])
        8'd0: begin r = a + b; c = (r > mask); end
        8'd1: begin c = (a < b); r = a - b; end
        8'd2: r = a & b;
        8'd3: r = a | b;
        8'd4: r = a ^ b;
        8'd5: r = a << (b % W);
        8'd6: r = a >> (b % W);
        default: bad = 1'b1;
      endcase
    end
    if (bad) begin
      exp_d.push_back(8'hFF);
      exp_u = 4'b1000;
    end else begin
      r = r & mask;
      for (int i = 0; i < OB; i++) exp_d.push_back(8'((r >> (8 * i)) & 8'hFF));
      exp_u = {1'b0, 1'((r >> (W - 1)) & 1), (r == 0), c};
      exp_led = LEDW'(r);
    end
  endtask

  task automatic test_reset();
    arst = 1'b1;
    cycle();
    cycle();
    total++; if (s_tready !== 1'b0) $display("FAIL reset_s_tready: got %b, required 0", s_tready); else passed++;
    total++; if (m_tvalid !== 1'b0) $display("FAIL reset_m_tvalid: got %b, required 0", m_tvalid); else passed++;
    total++; if (m_tdata !== 8'h00 || m_tlast !== 1'b0 || m_tuser !== 4'h0)
      $display("FAIL reset_m_payload: got d=%h l=%b u=%b, required 0/0/0", m_tdata, m_tlast, m_tuser); else passed++;
    total++; if (led !== '0) $display("FAIL reset_led: got %h, required 0000", led); else passed++;
    arst = 1'b0;
    total++; if (s_tready !== 1'b0) $display("FAIL release_before_edge: got %b, required 0", s_tready); else passed++;
    cycle();
    total++; if (s_tready !== 1'b1) $display("FAIL ready_after_release: got %b, required 1", s_tready); else passed++;
  endtask

  task automatic test_add();
    logic [7:0] e[2] = '{8'h00, 8'h00};
    pb.delete(); pl.delete();
    add(8'h00, 0); add(8'hFF, 0); add(8'hFF, 0); add(8'h01, 0); add(8'h00, 1);
    send_pkt(0);
    total++; if (m_tvalid !== 1'b0) $display("FAIL add_latency_edge1: got tvalid %b, required 0", m_tvalid); else passed++;
    cycle();
    total++; if (m_tvalid !== 1'b1) $display("FAIL add_latency_edge2: got tvalid %b, required 1", m_tvalid); else passed++;
    recv_resp(0, 0);
    total++;
    if (rx_d.size() != 2) $display("FAIL add_len: got %0d, required 2", rx_d.size());
    else begin
      passed++;
      for (int i = 0; i < 2; i++) begin
        total++;
        if (rx_d[i] !== e[i] || rx_l[i] !== (i == 1) || rx_u[i] !== 4'b0011)
          $display("FAIL add_byte%0d: got d=%h l=%b u=%b, required d=%h l=%b u=0011", i, rx_d[i], rx_l[i], rx_u[i], e[i], (i == 1));
        else passed++;
      end
    end
    exp_led = 16'h0000;
    total++; if (led !== exp_led) $display("FAIL add_led: got %h, required %h", led, exp_led); else passed++;
  endtask

  task automatic test_sub();
    logic [7:0] e[2] = '{8'hFE, 8'hFF};
    pb.delete(); pl.delete();
    add(8'h01, 0); add(8'h05, 0); add(8'h00, 0); add(8'h07, 0); add(8'h00, 1);
    send_pkt(0);
    recv_resp(0, 0);
    total++;
    if (rx_d.size() != 2) $display("FAIL sub_len: got %0d, required 2", rx_d.size());
    else begin
      passed++;
      for (int i = 0; i < 2; i++) begin
        total++;
        if (rx_d[i] !== e[i] || rx_l[i] !== (i == 1) || rx_u[i] !== 4'b0101)
          $display("FAIL sub_byte%0d: got d=%h l=%b u=%b, required d=%h l=%b u=0101", i, rx_d[i], rx_l[i], rx_u[i], e[i], (i == 1));
        else passed++;
      end
    end
    exp_led = 16'hFFFE;
    total++; if (led !== exp_led) $display("FAIL sub_led: got %h, required %h", led, exp_led); else passed++;
  endtask

  task automatic test_short();
    logic [7:0] e[2] = '{8'h35, 8'h12};
    pb.delete(); pl.delete();
    add(8'h00, 0); add(8'h12, 1);
    send_pkt(0);
    recv_resp(0, 0);
    total++;
    if (rx_d.size() != 1 || rx_d[0] !== 8'hFF || rx_l[0] !== 1'b1 || rx_u[0] !== 4'b1000)
      $display("FAIL short_err: got %0d bytes first d=%h u=%b, required 1 byte FF u=1000",
               rx_d.size(), (rx_d.size() > 0) ? rx_d[0] : 8'hxx, (rx_u.size() > 0) ? rx_u[0] : 4'hx);
    else passed++;
    total++; if (led !== exp_led) $display("FAIL short_led: got %h, required %h", led, exp_led); else passed++;
    pb.delete(); pl.delete();
    add(8'h00, 0); add(8'h34, 0); add(8'h12, 0); add(8'h01, 0); add(8'h00, 1);
    send_pkt(0);
    recv_resp(0, 0);
    total++;
    if (rx_d.size() != 2) $display("FAIL short_next_len: got %0d, required 2", rx_d.size());
    else begin
      passed++;
      for (int i = 0; i < 2; i++) begin
        total++;
        if (rx_d[i] !== e[i] || rx_l[i] !== (i == 1) || rx_u[i] !== 4'b0000)
          $display("FAIL short_next_byte%0d: got d=%h l=%b u=%b, required d=%h l=%b u=0000", i, rx_d[i], rx_l[i], rx_u[i], e[i], (i == 1));
        else passed++;
      end
    end
    exp_led = 16'h1235;
    total++; if (led !== exp_led) $display("FAIL short_next_led: got %h, required %h", led, exp_led); else passed++;
  endtask

  task automatic test_long();
    pb.delete(); pl.delete();
    add(8'h02, 0); add(8'h0F, 0); add(8'h00, 0); add(8'h03, 0); add(8'h00, 0); add(8'hAA, 0); add(8'hBB, 1);
    send_pkt(0);
    recv_resp(0, 0);
    total++;
    if (rx_d.size() != 1 || rx_d[0] !== 8'hFF || rx_l[0] !== 1'b1 || rx_u[0] !== 4'b1000)
      $display("FAIL long_err: got %0d bytes first d=%h u=%b, required 1 byte FF u=1000",
               rx_d.size(), (rx_d.size() > 0) ? rx_d[0] : 8'hxx, (rx_u.size() > 0) ? rx_u[0] : 4'hx);
    else passed++;
    total++; if (led !== exp_led) $display("FAIL long_led: got %h, required %h", led, exp_led); else passed++;
  endtask

  task automatic test_shl_backpressure();
    logic [7:0] e[2] = '{8'h02, 8'h00};
    pb.delete(); pl.delete();
    add(8'h05, 0); add(8'h01, 0); add(8'h00, 0); add(8'h11, 0); add(8'h00, 1);
    send_pkt(0);
    recv_resp(3, 0);
    total++;
    if (rx_d.size() != 2) $display("FAIL shl_len: got %0d, required 2", rx_d.size());
    else begin
      passed++;
      for (int i = 0; i < 2; i++) begin
        total++;
        if (rx_d[i] !== e[i] || rx_l[i] !== (i == 1) || rx_u[i] !== 4'b0000)
          $display("FAIL shl_byte%0d: got d=%h l=%b u=%b, required d=%h l=%b u=0000", i, rx_d[i], rx_l[i], rx_u[i], e[i], (i == 1));
        else passed++;
      end
    end
    exp_led = 16'h0002;
    total++; if (led !== exp_led) $display("FAIL shl_led: got %h, required %h", led, exp_led); else passed++;
  endtask

  task automatic test_reset_mid_tx();
    logic [7:0] e[2] = '{8'h0F, 8'hF0};
    int g = 0;
    bit spurious = 1'b0;
    pb.delete(); pl.delete();
    add(8'h06, 0); add(8'h00, 0); add(8'hF0, 0); add(8'h04, 0); add(8'h00, 1);
    send_pkt(0);
    while (!m_tvalid && g < 20) begin
      cycle();
      g++;
    end
    total++; if (m_tvalid !== 1'b1 || m_tdata !== 8'h00)
      $display("FAIL rst_tx_byte0: got v=%b d=%h, required v=1 d=00", m_tvalid, m_tdata); else passed++;
    m_tready = 1'b1;
    cycle();
    arst = 1'b1;
    #1;
    total++; if (m_tvalid !== 1'b0) $display("FAIL rst_tx_async: got tvalid %b, required 0", m_tvalid); else passed++;
    m_tready = 1'b0;
    cycle();
    cycle();
    arst = 1'b0;
    exp_led = '0;
    total++; if (led !== exp_led) $display("FAIL rst_tx_led: got %h, required %h", led, exp_led); else passed++;
    cycle();
    total++; if (s_tready !== 1'b1) $display("FAIL rst_tx_ready: got %b, required 1", s_tready); else passed++;
    m_tready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (m_tvalid !== 1'b0) spurious = 1'b1;
      cycle();
    end
    m_tready = 1'b0;
    total++; if (spurious) $display("FAIL rst_tx_no_byte1: got tvalid after reset, required none"); else passed++;
    pb.delete(); pl.delete();
    add(8'h04, 0); add(8'hF0, 0); add(8'h0F, 0); add(8'hFF, 0); add(8'hFF, 1);
    send_pkt(0);
    recv_resp(0, 0);
    total++;
    if (rx_d.size() != 2) $display("FAIL xor_len: got %0d, required 2", rx_d.size());
    else begin
      passed++;
      for (int i = 0; i < 2; i++) begin
        total++;
        if (rx_d[i] !== e[i] || rx_l[i] !== (i == 1) || rx_u[i] !== 4'b0100)
          $display("FAIL xor_byte%0d: got d=%h l=%b u=%b, required d=%h l=%b u=0100", i, rx_d[i], rx_l[i], rx_u[i], e[i], (i == 1));
        else passed++;
      end
    end
    exp_led = 16'hF00F;
    total++; if (led !== exp_led) $display("FAIL xor_led: got %h, required %h", led, exp_led); else passed++;
  endtask

  task automatic test_random();
    for (int it = 0; it < 40; it++) begin
      int n = 1 + 2 * OB;
      int kind = $urandom_range(9);
      int len = n;
      if (kind == 0) len = $urandom_range(n - 1, 1);
      else if (kind == 1) len = n + $urandom_range(3, 1);
      pb.delete(); pl.delete();
      for (int i = 0; i < len; i++) begin
        int sel = $urandom_range(5);
        logic [7:0] v = 8'($urandom);
        if (i == 0) v = 8'($urandom_range(8));
        else if (sel == 0) v = 8'h00;
        else if (sel == 1) v = 8'hFF;
        add(v, (i == len - 1));
      end
      model();
      send_pkt(30);
      recv_resp(0, 30);
      total++;
      if (rx_d.size() != exp_d.size())
        $display("FAIL rand%0d_len: got %0d, required %0d", it, rx_d.size(), exp_d.size());
      else begin
        passed++;
        for (int i = 0; i < exp_d.size(); i++) begin
          total++;
          if (rx_d[i] !== exp_d[i] || rx_l[i] !== (i == exp_d.size() - 1) || rx_u[i] !== exp_u)
            $display("FAIL rand%0d_byte%0d op=%h: got d=%h l=%b u=%b, required d=%h l=%b u=%b",
                     it, i, pb[0], rx_d[i], rx_l[i], rx_u[i], exp_d[i], (i == exp_d.size() - 1), exp_u);
          else passed++;
        end
      end
      total++; if (led !== exp_led) $display("FAIL rand%0d_led: got %h, required %h", it, led, exp_led); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_short();
    test_long();
    test_shl_backpressure();
    test_reset_mid_tx();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/axis_alu.md
AXIS_ALU -- requirements
Module: axis_alu

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; all flops SHALL be clocked on the rising edge of aclk_i.
REQ-002 Parameter OPERAND_BYTES SHALL default to 2 and set operand/result width W = 8*OPERAND_BYTES (legal 1..8).
REQ-003 Parameter LED_WIDTH SHALL default to 16 and set the LED output width.
REQ-004 Ports SHALL be exactly these; bytes outside this list SHALL not exist:
  aclk_i           in   1          clock
  arst_i           in   1          async reset, active-high
  s_axis_tdata_i   in   8          command byte stream
  s_axis_tvalid_i  in   1          input byte valid
  s_axis_tlast_i   in   1          last byte of command packet
  s_axis_tready_o  out  1          block accepts input byte
  m_axis_tdata_o   out  8          response byte stream
  m_axis_tvalid_o  out  1          response byte valid
  m_axis_tlast_o   out  1          last byte of response packet
  m_axis_tuser_o   out  4          flags {error, negative, zero, carry} (bit3..bit0)
  m_axis_tready_i  in   1          downstream accepts byte
  led_o            out  LED_WIDTH  last good result

Function
REQ-005 A byte SHALL transfer on an edge where tvalid and tready are both high, on either port.
REQ-006 A well-formed command SHALL be 1+2*OPERAND_BYTES bytes: opcode, operand A little-endian, operand B little-endian, tlast on the final byte only.
REQ-007 States SHALL be OPC, RX_A, RX_B, EXEC, TX, DRAIN, ERR_TX; s_axis_tready_o SHALL be high only in OPC, RX_A, RX_B, DRAIN.
REQ-008 OPC->RX_A on opcode accept; RX_A->RX_B after OPERAND_BYTES bytes; RX_B->EXEC on final B byte with tlast.
REQ-009 tlast on any byte before the final B byte SHALL end the packet and go to ERR_TX.
REQ-010 Final B byte without tlast SHALL go to DRAIN; DRAIN SHALL discard bytes through the next tlast, then go to ERR_TX.
REQ-011 Opcodes (W-bit, wrap-around): 0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 XOR, 5 SHL (A<<B mod W), 6 SHR logical (A>>B mod W); opcode >6 SHALL go to ERR_TX after the full packet is received.
REQ-012 EXEC SHALL last one cycle: result and flags registered, then TX; m_axis_tvalid_o SHALL rise on the 2nd edge after the final input handshake.
REQ-013 carry = carry-out for ADD, borrow (A<B unsigned) for SUB, 0 otherwise; zero = (result==0); negative = result[W-1]; error = 0.
REQ-014 TX SHALL emit OPERAND_BYTES result bytes LSB first, tlast on the last, tuser constant across the packet, then return to OPC.
REQ-015 ERR_TX SHALL emit one byte 0xFF with tlast=1 and tuser=4'b1000, then return to OPC.
REQ-016 While m_axis_tvalid_o && !m_axis_tready_i, tdata, tlast, tuser SHALL hold stable; tvalid SHALL not drop until accepted.
REQ-017 m_axis_tvalid_o SHALL depend only on state, never combinationally on m_axis_tready_i.
REQ-018 led_o SHALL update in EXEC with result[LED_WIDTH-1:0] (zero-extended if W<LED_WIDTH) for valid opcodes only; errors SHALL leave it unchanged.
REQ-019 s_axis_tvalid_i low mid-packet SHALL stall reception indefinitely without error.

Reset
REQ-020 While arst_i is high: state=OPC, byte counters=0, s_axis_tready_o=0, m_axis_tvalid_o=0, m_axis_tdata_o=0, m_axis_tlast_o=0, m_axis_tuser_o=0, led_o=0.
REQ-021 Reset mid-packet or mid-response SHALL abandon it with no further output bytes; first byte after release SHALL be treated as an opcode.
REQ-022 s_axis_tready_o SHALL rise on the first edge after arst_i deasserts.

Verification (OPERAND_BYTES=2, LED_WIDTH=16)
REQ-023 ADD 00,FF,FF,01,00(tlast) -> 00,00(tlast), tuser=4'b0011, led_o=0x0000, tvalid 2 edges after last input.
REQ-024 SUB 01,05,00,07,00(tlast) -> FE,FF(tlast), tuser=4'b0101, led_o=0xFFFE.
REQ-025 Short 00,12(tlast) -> FF(tlast), tuser=4'b1000, led_o unchanged; next well-formed command correct.
REQ-026 Long 02,0F,00,03,00,AA,BB(tlast) -> bytes AA,BB dropped, single FF(tlast) error response after BB accepted.
REQ-027 SHL 05,01,00,11,00 with m_axis_tready_i low 3 cycles during byte 0 -> 02,00(tlast), data held stable, s_axis_tready_o low throughout TX.
REQ-028 arst_i pulsed during TX after byte 0 -> tvalid=0 immediately, no byte 1; following XOR 04,F0,0F,FF,FF -> 0F,F0, tuser=4'b0100.
